// File: rtl/baud_pkg.sv
// -----------------------------------------------------------------------------
// baud_pkg
// Shared constants and types for the UART baud-rate tick generator.
// Defines the system clock rate, the default oversample ratio, the standard
// divisor pairs for 9600 and 115200 baud, and the divisor payload type.
// Fraction unit for every divisor below is 1/16 clock (4 fractional bits).
// -----------------------------------------------------------------------------
package baud_pkg;

  localparam int unsigned CLK_HZ       = 100_000_000;
  localparam int unsigned BAUD_OSR_DEF = 16;

  localparam int unsigned BAUD_DIV_W  = 16;
  localparam int unsigned BAUD_FRAC_W = 4;

  // Divisor payload as delivered by the register interface.
  typedef struct packed {
    logic [BAUD_DIV_W-1:0]  div_int;
    logic [BAUD_FRAC_W-1:0] div_frac;
  } baud_div_t;

  // 100 MHz / 16 / 9600   = 651.04 -> 651 + 1/16
  localparam baud_div_t BAUD_DIV_9600 = '{
    div_int:  BAUD_DIV_W'(651),
    div_frac: BAUD_FRAC_W'(1)
  };

  // 100 MHz / 16 / 115200 = 54.25  -> 54 + 4/16
  localparam baud_div_t BAUD_DIV_115200 = '{
    div_int:  BAUD_DIV_W'(54),
    div_frac: BAUD_FRAC_W'(4)
  };

endpackage : baud_pkg

// File: rtl/baud_frac_acc.sv
// -----------------------------------------------------------------------------
// baud_frac_acc
// Fractional phase accumulator for the baud tick generator. On every period
// boundary the active fractional divisor is added modulo 2^FRAC_W; the carry
// out is registered and stretches the following period by one clock.
// Only present when BAUD_FRAC_EN is defined.
//
// Ports:
//   clk      in   system clock
//   resetn   in   asynchronous active-low reset
//   clear_i  in   re-phase strobe: clears accumulator and carry
//   step_i   in   period boundary: accumulate frac_i
//   frac_i   in   active fractional divisor (FRAC_W)
//   carry_o  out  registered carry, extends the next period by one clock
// -----------------------------------------------------------------------------
`ifdef BAUD_FRAC_EN
module baud_frac_acc #(
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              carry_o
);

  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W-1:0] acc_d;
  logic              carry_q;
  logic              carry_d;
  logic [FRAC_W:0]   sum;

  // Accumulator state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  // Clear wins over accumulate; carry holds between boundaries.
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    sum     = {1'b0, acc_q} + {1'b0, frac_i};
    if (clear_i) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (step_i) begin
      acc_d   = sum[FRAC_W-1:0];
      carry_d = sum[FRAC_W];
    end
  end

  assign carry_o = carry_q;

endmodule : baud_frac_acc
`endif

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Fractional baud-rate tick generator for the UART Rx/Tx path. Produces an
// oversample tick every P clocks (P = max(act_int,1) + fractional carry), a
// bit tick every OSR oversample ticks and a mid-bit tick half way through.
// Divisors are loaded into a pending shadow and switched in at the next
// oversample boundary so the period in flight always completes unchanged.
// restart re-phases everything to a detected start-bit edge.
//
// Build option: BAUD_FRAC_EN enables the fractional accumulator (div_frac);
// without it div_frac is ignored and P = max(act_int,1).
//
// Ports:
//   clk       in   system clock
//   resetn    in   asynchronous active-low reset
//   en        in   count enable; low freezes counters (load still captured)
//   div_int   in   integer divisor, clocks per oversample tick (DIV_W)
//   div_frac  in   fractional divisor, 1/2^FRAC_W clock units (FRAC_W)
//   load      in   capture div_int/div_frac into the pending registers
//   restart   in   clear all counters, apply pending divisor immediately
//   os_tick   out  one-clock pulse at OSR x baud
//   bit_tick  out  one-clock pulse once per bit (with an os_tick)
//   mid_tick  out  one-clock pulse at mid-bit (with an os_tick)
// -----------------------------------------------------------------------------
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W        = BAUD_DIV_W,
  parameter int unsigned FRAC_W       = BAUD_FRAC_W,
  parameter int unsigned OSR          = BAUD_OSR_DEF,
  parameter int unsigned DEF_DIV_INT  = 54,
  parameter int unsigned DEF_DIV_FRAC = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              load,
  input  logic              restart,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              mid_tick
);

  localparam int unsigned CNT_W = DIV_W + 1;
  localparam int unsigned OS_W  = $clog2(OSR);

  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0]  OS_MID  = OS_W'((OSR / 2) - 1);
  localparam logic [DIV_W-1:0] DEF_INT = DIV_W'(DEF_DIV_INT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [OS_W-1:0]  os_cnt_q;
  logic [OS_W-1:0]  os_cnt_d;
  logic [DIV_W-1:0] act_int_q;
  logic [DIV_W-1:0] act_int_d;
  logic [DIV_W-1:0] pend_int_q;
  logic [DIV_W-1:0] pend_int_d;
  logic             pend_vld_q;
  logic             pend_vld_d;

  logic             os_tick_q;
  logic             os_tick_d;
  logic             bit_tick_q;
  logic             bit_tick_d;
  logic             mid_tick_q;
  logic             mid_tick_d;

  logic [DIV_W-1:0] div_eff;
  logic [CNT_W-1:0] period;
  logic             frac_carry;
  logic             wrap;
  logic             step;
  logic             swap;

  // Period length for the period in flight; one extra bit so carry never wraps.
  always_comb begin
    div_eff = (act_int_q == '0) ? DIV_W'(1) : act_int_q;
    period  = {1'b0, div_eff} + CNT_W'(frac_carry);
    wrap    = (cnt_q == (period - CNT_W'(1)));
  end

  // step: an oversample boundary happens on this edge.
  // swap: the active divisor may be replaced on this edge.
  assign step = en && !restart && wrap;
  assign swap = restart || step;

  // ---------------------------------------------------------------------------
  // Optional fractional path
  // ---------------------------------------------------------------------------
`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] act_frac_q;
  logic [FRAC_W-1:0] act_frac_d;
  logic [FRAC_W-1:0] pend_frac_q;
  logic [FRAC_W-1:0] pend_frac_d;

  // Accumulates the divisor of the period that just ended, before any swap.
  baud_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk     (clk),
    .resetn  (resetn),
    .clear_i (restart),
    .step_i  (step),
    .frac_i  (act_frac_q),
    .carry_o (frac_carry)
  );

  // Fractional divisor shadow registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      act_frac_q  <= FRAC_W'(DEF_DIV_FRAC);
      pend_frac_q <= FRAC_W'(DEF_DIV_FRAC);
    end else begin
      act_frac_q  <= act_frac_d;
      pend_frac_q <= pend_frac_d;
    end
  end

  // A load on the swap edge bypasses the pending register.
  always_comb begin
    act_frac_d  = act_frac_q;
    pend_frac_d = pend_frac_q;
    if (load) begin
      pend_frac_d = div_frac;
    end
    if (swap) begin
      if (load) begin
        act_frac_d = div_frac;
      end else if (pend_vld_q) begin
        act_frac_d = pend_frac_q;
      end
    end
  end
`else
  assign frac_carry = 1'b0;

  logic unused_frac;
  assign unused_frac = ^{div_frac, FRAC_W'(DEF_DIV_FRAC)};
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      os_cnt_q   <= '0;
      act_int_q  <= DEF_INT;
      pend_int_q <= DEF_INT;
      pend_vld_q <= 1'b0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      os_cnt_q   <= os_cnt_d;
      act_int_q  <= act_int_d;
      pend_int_q <= pend_int_d;
      pend_vld_q <= pend_vld_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: counters and divisor shadows
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d      = cnt_q;
    os_cnt_d   = os_cnt_q;
    act_int_d  = act_int_q;
    pend_int_d = pend_int_q;
    pend_vld_d = pend_vld_q;

    // Period counter: restart clears regardless of en.
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : (cnt_q + CNT_W'(1));
    end

    // Oversample position within the bit.
    if (restart) begin
      os_cnt_d = '0;
    end else if (step) begin
      os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : (os_cnt_q + OS_W'(1));
    end

    // Load always refreshes the shadow; it only becomes active on a swap edge.
    if (load) begin
      pend_int_d = div_int;
    end
    if (swap) begin
      pend_vld_d = 1'b0;
      if (load) begin
        act_int_d = div_int;
      end else if (pend_vld_q) begin
        act_int_d = pend_int_q;
      end
    end else if (load) begin
      pend_vld_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: ticks are registered off the boundary edge
  // ---------------------------------------------------------------------------
  always_comb begin
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;
    if (step) begin
      os_tick_d  = 1'b1;
      bit_tick_d = (os_cnt_q == OS_LAST);
      mid_tick_d = (os_cnt_q == OS_MID);
    end
  end

  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;
  assign mid_tick = mid_tick_q;

endmodule : baud_tick_gen

// File: tb/tb_baud_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_baud_tick_gen
// Self-checking bench for baud_tick_gen: per-cycle comparison of all three
// ticks against a countdown-based reference model, a table of period
// sequences, directed multi-cycle corner cases and a randomized phase.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_baud_tick_gen;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OSR    = 16;
  localparam int FMOD   = 16;
  localparam int LIMIT  = 2000;

`ifdef BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetn;
  logic              en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              load;
  logic              restart;
  logic              os_tick;
  logic              bit_tick;
  logic              mid_tick;

  always #5 clk = ~clk;

  baud_tick_gen dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .div_int  (div_int),
    .div_frac (div_frac),
    .load     (load),
    .restart  (restart),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .mid_tick (mid_tick)
  );

  int n_checks;
  int n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining clocks in the current period, counted down.
  int m_act_int, m_act_frac, m_pend_int, m_pend_frac;
  bit m_pv;
  int m_acc, m_carry, m_rem, m_os;
  bit e_os, e_bit, e_mid;

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_act_int = 54; m_act_frac = 4; m_pend_int = 54; m_pend_frac = 4;
    m_pv = 1'b0; m_acc = 0; m_carry = 0; m_os = 0;
    m_rem = 54;
    e_os = 1'b0; e_bit = 1'b0; e_mid = 1'b0;
  endtask

  task automatic model_edge();
    bit apply;
    apply = 1'b0;
    e_os = 1'b0; e_bit = 1'b0; e_mid = 1'b0;
    if (restart) begin
      m_acc = 0; m_carry = 0; m_os = 0;
      apply = 1'b1;
    end else if (en) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        e_os  = 1'b1;
        e_bit = (m_os == OSR - 1);
        e_mid = (m_os == OSR / 2 - 1);
        m_os  = (m_os + 1) % OSR;
        if (FRAC_ON) begin
          m_acc   = m_acc + m_act_frac;
          m_carry = m_acc / FMOD;
          m_acc   = m_acc % FMOD;
        end
        apply = 1'b1;
      end
    end
    if (apply) begin
      if (load) begin
        m_act_int = int'(div_int); m_act_frac = int'(div_frac);
      end else if (m_pv) begin
        m_act_int = m_pend_int; m_act_frac = m_pend_frac;
      end
      m_pv  = 1'b0;
      m_rem = max1(m_act_int) + m_carry;
    end else if (load) begin
      m_pv = 1'b1;
    end
    if (load) begin
      m_pend_int = int'(div_int); m_pend_frac = int'(div_frac);
    end
  endtask

  // One clock: advance model on the edge, compare all ticks 1 ns later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("ticks{os,bit,mid}", int'({os_tick, bit_tick, mid_tick}),
          int'({e_os, e_bit, e_mid}));
  endtask

  // Edges until the next os_tick is observed (bounded).
  task automatic wait_tick(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int k = 0; k < LIMIT && !seen; k++) begin
      cyc();
      n++;
      if (os_tick) seen = 1'b1;
    end
    if (!seen) check("os_tick_timeout", 0, 1);
  endtask

  task automatic restart_with(input int di, input int df);
    div_int  = DIV_W'(di);
    div_frac = FRAC_W'(df);
    load     = 1'b1;
    restart  = 1'b1;
    cyc();
    load     = 1'b0;
    restart  = 1'b0;
  endtask

  typedef struct {
    int di;
    int df;
    int p0, p1, p2, p3, p4;
  } vec_t;

  function automatic int vec_p(input vec_t v, input int k);
    case (k)
      0: return v.p0;
      1: return v.p1;
      2: return v.p2;
      3: return v.p3;
      default: return v.p4;
    endcase
  endfunction

  initial begin
    vec_t vecs[5];
    int n, tot, first_mid, first_bit, second_bit;

    n_checks = 0; n_fail = 0;
    resetn = 1'b0; en = 1'b0; load = 1'b0; restart = 1'b0;
    div_int = '0; div_frac = '0;
    model_reset();

    // Period sequences after a restart with each divisor pair.
    vecs[0] = '{4, 0, 4, 4, 4, 4, 4};
    vecs[1] = '{0, 0, 1, 1, 1, 1, 1};
    vecs[2] = '{1, 8, 1, 1, FRAC_ON ? 2 : 1, 1, FRAC_ON ? 2 : 1};
    vecs[3] = '{54, 4, 54, 54, 54, 54, FRAC_ON ? 55 : 54};
    vecs[4] = '{5, 12, 5, 5, FRAC_ON ? 6 : 5, FRAC_ON ? 6 : 5, FRAC_ON ? 6 : 5};

    // Reset state.
    #12;
    check("reset_os_tick", int'(os_tick), 0);
    check("reset_bit_tick", int'(bit_tick), 0);
    check("reset_mid_tick", int'(mid_tick), 0);
    @(negedge clk);
    resetn = 1'b1;
    en = 1'b1;
    wait_tick(n);
    check("default_first_period", n, 54);

    // Table: period sequences.
    for (int i = 0; i < 5; i++) begin
      restart_with(vecs[i].di, vecs[i].df);
      en = 1'b1;
      for (int k = 0; k < 5; k++) begin
        wait_tick(n);
        check($sformatf("vec%0d_period%0d", i, k), n, vec_p(vecs[i], k));
      end
    end

    // 16 periods at 115200 settings.
    restart_with(54, 4);
    tot = 0;
    for (int k = 0; k < 16; k++) begin
      wait_tick(n);
      tot += n;
    end
    check("sum16_periods", tot, FRAC_ON ? 868 : 864);

    // mid/bit tick placement with div 4.
    restart_with(4, 0);
    first_mid = -1; first_bit = -1; second_bit = -1;
    for (int k = 1; k <= 140; k++) begin
      cyc();
      if (mid_tick && first_mid < 0) first_mid = k;
      if (bit_tick) begin
        if (first_bit < 0) first_bit = k;
        else if (second_bit < 0) second_bit = k;
      end
    end
    check("first_mid_tick", first_mid, 32);
    check("first_bit_tick", first_bit, 64);
    check("second_bit_tick", second_bit, 128);

    // Load during a period: the running period finishes with the old divisor.
    restart_with(4, 0);
    cyc(); cyc();
    div_int = DIV_W'(8); div_frac = '0; load = 1'b1;
    cyc();
    load = 1'b0;
    wait_tick(n);
    check("load_old_period", 3 + n, 4);
    wait_tick(n);
    check("load_new_period", n, 8);

    // restart at os_cnt = 10, on the edge that would otherwise tick.
    restart_with(4, 0);
    for (int k = 0; k < 10; k++) wait_tick(n);
    cyc(); cyc(); cyc();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    check("restart_edge_no_tick", int'(os_tick), 0);
    first_mid = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (mid_tick && first_mid < 0) first_mid = k;
    end
    check("restart_mid_latency", first_mid, 32);

    // en low mid-period holds the count.
    restart_with(4, 0);
    cyc(); cyc();
    en = 1'b0;
    tot = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      tot += int'(os_tick);
    end
    check("en_low_no_ticks", tot, 0);
    en = 1'b1;
    wait_tick(n);
    check("en_resume_remaining", n, 2);

    // Asynchronous reset while a tick is high.
    restart_with(0, 0);
    cyc(); cyc();
    check("div0_tick_high", int'(os_tick), 1);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_os", int'(os_tick), 0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    wait_tick(n);
    check("post_reset_period", n, 54);

    // Randomized phase against the model.
    restart_with(3, 5);
    for (int k = 0; k < 5000; k++) begin
      en       = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 24) == 0);
      restart  = ($urandom_range(0, 149) == 0);
      div_int  = DIV_W'($urandom_range(0, 6));
      div_frac = FRAC_W'($urandom_range(0, 15));
      cyc();
    end
    load = 1'b0; restart = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_baud_tick_gen
